// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
//
// Watches the committed-PC stream of a core under test. It stops the run when
// one of three things happens:
//   - END_PC is committed (halt_cause 1),
//   - TIMEOUT cycles are spent in RUN (halt_cause 2),
//   - the same PC is committed STUCK_LIMIT times in a row (halt_cause 3).
// Cause 3 exists only when MON_STUCK_DETECT_EN is defined.
// After a halt, the monitor reads all NREGS registers through reg_sel/reg_data.
// It streams each one out as a valid/ready beat and then parks in DONE.
//
// Optional feature macro: MON_STUCK_DETECT_EN (stuck-PC detector)
//
// Ports
//   clk          in   sole clock, rising edge
//   rstn         in   asynchronous active-low reset
//   pc_in        in   committed PC
//   pc_valid     in   pc_in is a commit this cycle
//   reg_sel      out  register-file read address
//   reg_data     in   combinational read data for reg_sel
//   dump_valid   out  dump_idx/dump_data hold a dump beat
//   dump_ready   in   consumer accepts the beat
//   dump_idx     out  index of the dumped register
//   dump_data    out  dumped register value
//   halted       out  a halt condition has occurred
//   halt_cause   out  0 none, 1 END_PC, 2 timeout, 3 stuck PC
//   done         out  dump complete
//   cycle_count  out  cycles spent in RUN
// -----------------------------------------------------------------------------
module run_monitor #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] END_PC      = PC_W'(32'h0000_0048),
    parameter int              TIMEOUT     = 1000,
    parameter int              CNT_W       = 16,
    parameter int              NREGS       = 32,
    parameter int              STUCK_LIMIT = 16,
    localparam int             REG_AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              pc_valid,
    output logic [REG_AW-1:0] reg_sel,
    input  logic [31:0]       reg_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [REG_AW-1:0] dump_idx,
    output logic [31:0]       dump_data,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count
);

    // Reject parameter sets the counters cannot represent.
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_chk_cnt_w
        $error("run_monitor: CNT_W too narrow for TIMEOUT");
    end
    if (STUCK_LIMIT < 2) begin : g_chk_stuck_limit
        $error("run_monitor: STUCK_LIMIT must be at least 2");
    end
    if (NREGS < 2) begin : g_chk_nregs
        $error("run_monitor: NREGS must be at least 2");
    end

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_DUMP_RD  = 2'd1,
        S_DUMP_OUT = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREGS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_AW-1:0]  idx_q, idx_d;
    logic [REG_AW-1:0]  dump_idx_q, dump_idx_d;
    logic [31:0]        dump_data_q, dump_data_d;
    logic               halted_q, halted_d;
    logic [1:0]         cause_q, cause_d;
    logic               stuck_det;

`ifdef MON_STUCK_DETECT_EN
    // The stuck counter holds (run length - 1) of identical consecutive commits.
    // An equal commit that lifts it to STUCK_LIMIT-1 is the hang.
    localparam int              STK_W   = $clog2(STUCK_LIMIT);
    localparam logic [STK_W-1:0] STK_ARM = STK_W'(STUCK_LIMIT - 2);

    logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
    logic             prev_vld_q, prev_vld_d;
    logic [STK_W-1:0] stuck_q, stuck_d;
    logic             same_pc;

    // prev_vld_q keeps the first commit after reset from matching the reset
    // value of prev_pc_q.
    assign same_pc   = pc_valid && prev_vld_q && (pc_in == prev_pc_q);
    assign stuck_det = (state_q == S_RUN) && same_pc && (stuck_q == STK_ARM);

    always_comb begin
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;
        stuck_d    = stuck_q;
        if (state_q == S_RUN && pc_valid) begin
            prev_pc_d  = pc_in;
            prev_vld_d = 1'b1;
            stuck_d    = same_pc ? stuck_q + STK_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            stuck_q    <= '0;
        end else begin
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            stuck_q    <= stuck_d;
        end
    end
`else
    assign stuck_det = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;
        halted_d    = halted_q;
        cause_d     = cause_q;

        unique case (state_q)
            S_RUN: begin
                if (pc_valid && pc_in == END_PC) begin
                    state_d  = S_DUMP_RD;
                    halted_d = 1'b1;
                    cause_d  = 2'd1;
                    idx_d    = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = S_DUMP_RD;
                    halted_d = 1'b1;
                    cause_d  = 2'd2;
                    idx_d    = '0;
                end else if (stuck_det) begin
                    state_d  = S_DUMP_RD;
                    halted_d = 1'b1;
                    cause_d  = 2'd3;
                    idx_d    = '0;
                end else begin
                    // The halting cycle does not count, so a timeout
                    // leaves cycle_count at TIMEOUT-1.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DUMP_RD: begin
                // reg_sel has been driving idx_q all cycle; capture the read.
                dump_data_d = reg_data;
                dump_idx_d  = idx_q;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + REG_AW'(1);
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            idx_q       <= '0;
            dump_idx_q  <= '0;
            dump_data_q <= '0;
            halted_q    <= 1'b0;
            cause_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
            halted_q    <= halted_d;
            cause_q     <= cause_d;
        end
    end

    assign reg_sel     = idx_q;
    assign dump_valid  = (state_q == S_DUMP_OUT);
    assign dump_idx    = dump_idx_q;
    assign dump_data   = dump_data_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign done        = (state_q == S_DONE);
    assign cycle_count = cnt_q;

endmodule
